// File: rtl/roce_write_sequencer_if.sv
// RoCE write header channel between roce_write_sequencer and its header consumer.
//
// The sequencer (master) presents one BTH/RETH header per transaction on this
// channel; the consumer (slave) accepts it with m_roce_bth_ready. A header is
// transferred on a cycle where m_roce_bth_valid and m_roce_bth_ready are both high.
//
// Signals:
//   m_roce_bth_valid       header present
//   m_roce_bth_ready       consumer accepts header (slave -> master)
//   m_roce_bth_op_code     BTH opcode
//   m_roce_bth_psn         BTH packet sequence number
//   m_roce_bth_dest_qp     BTH destination queue pair
//   m_roce_reth_v_addr     RETH virtual address of this packet's payload
//   m_roce_reth_r_key      RETH remote key
//   m_roce_reth_length     RETH total DMA length of the whole write
//   m_ip_dest_ip           destination IPv4 address
//   m_roce_payload_length  payload bytes carried by this packet
//   m_roce_immdt_data      immediate data (only with ROCE_WRITE_IMMDT_EN)
//
// Configuration macro: ROCE_WRITE_IMMDT_EN adds the immediate-data field.

interface roce_write_sequencer_if;
   logic        m_roce_bth_valid;
   logic        m_roce_bth_ready;
   logic [7:0]  m_roce_bth_op_code;
   logic [23:0] m_roce_bth_psn;
   logic [23:0] m_roce_bth_dest_qp;
   logic [63:0] m_roce_reth_v_addr;
   logic [31:0] m_roce_reth_r_key;
   logic [31:0] m_roce_reth_length;
   logic [31:0] m_ip_dest_ip;
   logic [15:0] m_roce_payload_length;
`ifdef ROCE_WRITE_IMMDT_EN
   logic [31:0] m_roce_immdt_data;
`endif

   modport master (
      output m_roce_bth_valid,
      output m_roce_bth_op_code,
      output m_roce_bth_psn,
      output m_roce_bth_dest_qp,
      output m_roce_reth_v_addr,
      output m_roce_reth_r_key,
      output m_roce_reth_length,
      output m_ip_dest_ip,
      output m_roce_payload_length,
`ifdef ROCE_WRITE_IMMDT_EN
      output m_roce_immdt_data,
`endif
      input  m_roce_bth_ready
   );

   modport slave (
      input  m_roce_bth_valid,
      input  m_roce_bth_op_code,
      input  m_roce_bth_psn,
      input  m_roce_bth_dest_qp,
      input  m_roce_reth_v_addr,
      input  m_roce_reth_r_key,
      input  m_roce_reth_length,
      input  m_ip_dest_ip,
      input  m_roce_payload_length,
`ifdef ROCE_WRITE_IMMDT_EN
      input  m_roce_immdt_data,
`endif
      output m_roce_bth_ready
   );
endinterface

// File: rtl/roce_write_sequencer.sv
// RoCE RDMA WRITE header sequencer.
//
// Splits one DMA write of dma_transfer bytes into ceil(dma_transfer / PMTU_BYTES)
// packets and issues one BTH/RETH header per packet on the hdr channel, one per
// cycle at full throughput. Launch is the rising edge of (start_transfer AND
// metadata_valid) seen in idle; all metadata is captured at launch.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_transfer     launch request (edge detected together with metadata_valid)
//   metadata_valid     metadata inputs are valid
//   dma_transfer       total write length in bytes
//   r_key, rem_qpn     remote key, destination queue pair
//   loc_psn            PSN of the first packet
//   rem_ip_addr        destination IPv4 address
//   rem_addr           remote virtual address of the first byte
//   immdt_data         immediate data (only with ROCE_WRITE_IMMDT_EN)
//   hdr                header channel (master side)
//   busy               high whenever not idle
//   transfer_done      one-cycle pulse when a transfer completes
//   next_psn           PSN following the last completed transfer
//
// Configuration macro: ROCE_WRITE_IMMDT_EN selects the LAST/ONLY-with-immediate
// opcodes and carries immdt_data in every header.

module roce_write_sequencer #(
   parameter int unsigned PMTU_BYTES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_transfer,
   input  logic                          metadata_valid,
   input  logic [31:0]                   dma_transfer,
   input  logic [31:0]                   r_key,
   input  logic [23:0]                   rem_qpn,
   input  logic [23:0]                   loc_psn,
   input  logic [31:0]                   rem_ip_addr,
   input  logic [63:0]                   rem_addr,
`ifdef ROCE_WRITE_IMMDT_EN
   input  logic [31:0]                   immdt_data,
`endif
   roce_write_sequencer_if.master        hdr,
   output logic                          busy,
   output logic                          transfer_done,
   output logic [23:0]                   next_psn
);

   localparam logic [31:0] Pmtu32 = 32'(PMTU_BYTES);
   localparam logic [63:0] Pmtu64 = 64'(PMTU_BYTES);

   localparam logic [7:0] OpFirst  = 8'h06;
   localparam logic [7:0] OpMiddle = 8'h07;
`ifdef ROCE_WRITE_IMMDT_EN
   localparam logic [7:0] OpLast   = 8'h09;
   localparam logic [7:0] OpOnly   = 8'h0B;
`else
   localparam logic [7:0] OpLast   = 8'h08;
   localparam logic [7:0] OpOnly   = 8'h0A;
`endif

   typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

   state_e      state_q, state_d;
   logic        launch_prev_q, launch_prev_d;
   logic        valid_q, valid_d;
   logic [7:0]  op_q, op_d;
   logic [23:0] psn_q, psn_d;
   logic [23:0] qp_q, qp_d;
   logic [63:0] vaddr_q, vaddr_d;
   logic [31:0] rkey_q, rkey_d;
   logic [31:0] len_q, len_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] pay_q, pay_d;
   // Bytes not yet covered by any presented header.
   logic [31:0] remain_q, remain_d;
   logic [23:0] next_psn_q, next_psn_d;
`ifdef ROCE_WRITE_IMMDT_EN
   logic [31:0] immdt_q, immdt_d;
`endif

   logic        launch_cond;
   logic        launch;
   logic [31:0] first_pay;
   logic [31:0] next_pay;

   assign launch_cond = start_transfer & metadata_valid;
   // launch_prev_q tracks the level in every state, so a level held across a
   // whole transfer cannot relaunch when the sequencer returns to idle.
   assign launch      = (state_q == StIdle) && launch_cond && !launch_prev_q;
   assign first_pay   = (dma_transfer > Pmtu32) ? Pmtu32 : dma_transfer;
   assign next_pay    = (remain_q > Pmtu32) ? Pmtu32 : remain_q;

   always_comb begin
      state_d       = state_q;
      launch_prev_d = launch_cond;
      valid_d       = valid_q;
      op_d          = op_q;
      psn_d         = psn_q;
      qp_d          = qp_q;
      vaddr_d       = vaddr_q;
      rkey_d        = rkey_q;
      len_d         = len_q;
      ip_d          = ip_q;
      pay_d         = pay_q;
      remain_d      = remain_q;
      next_psn_d    = next_psn_q;
`ifdef ROCE_WRITE_IMMDT_EN
      immdt_d       = immdt_q;
`endif

      case (state_q)
         StIdle: begin
            if (launch) begin
               state_d  = StIssue;
               // A zero-length write presents no header and falls through ISSUE.
               valid_d  = (dma_transfer != 32'd0);
               pay_d    = 16'(first_pay);
               remain_d = dma_transfer - first_pay;
               op_d     = ((dma_transfer - first_pay) == 32'd0) ? OpOnly : OpFirst;
               psn_d    = loc_psn;
               qp_d     = rem_qpn;
               vaddr_d  = rem_addr;
               rkey_d   = r_key;
               len_d    = dma_transfer;
               ip_d     = rem_ip_addr;
`ifdef ROCE_WRITE_IMMDT_EN
               immdt_d  = immdt_data;
`endif
            end
         end

         StIssue: begin
            if (!valid_q) begin
               state_d    = StDone;
               next_psn_d = psn_q;
            end else if (hdr.m_roce_bth_ready) begin
               if (remain_q == 32'd0) begin
                  valid_d    = 1'b0;
                  state_d    = StDone;
                  next_psn_d = psn_q + 24'd1;
               end else begin
                  pay_d    = 16'(next_pay);
                  remain_d = remain_q - next_pay;
                  op_d     = ((remain_q - next_pay) == 32'd0) ? OpLast : OpMiddle;
                  psn_d    = psn_q + 24'd1;
                  vaddr_d  = vaddr_q + Pmtu64;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         launch_prev_q <= 1'b0;
         valid_q       <= 1'b0;
         op_q          <= 8'd0;
         psn_q         <= 24'd0;
         qp_q          <= 24'd0;
         vaddr_q       <= 64'd0;
         rkey_q        <= 32'd0;
         len_q         <= 32'd0;
         ip_q          <= 32'd0;
         pay_q         <= 16'd0;
         remain_q      <= 32'd0;
         next_psn_q    <= 24'd0;
`ifdef ROCE_WRITE_IMMDT_EN
         immdt_q       <= 32'd0;
`endif
      end else begin
         state_q       <= state_d;
         launch_prev_q <= launch_prev_d;
         valid_q       <= valid_d;
         op_q          <= op_d;
         psn_q         <= psn_d;
         qp_q          <= qp_d;
         vaddr_q       <= vaddr_d;
         rkey_q        <= rkey_d;
         len_q         <= len_d;
         ip_q          <= ip_d;
         pay_q         <= pay_d;
         remain_q      <= remain_d;
         next_psn_q    <= next_psn_d;
`ifdef ROCE_WRITE_IMMDT_EN
         immdt_q       <= immdt_d;
`endif
      end
   end

   assign hdr.m_roce_bth_valid      = valid_q;
   assign hdr.m_roce_bth_op_code    = op_q;
   assign hdr.m_roce_bth_psn        = psn_q;
   assign hdr.m_roce_bth_dest_qp    = qp_q;
   assign hdr.m_roce_reth_v_addr    = vaddr_q;
   assign hdr.m_roce_reth_r_key     = rkey_q;
   assign hdr.m_roce_reth_length    = len_q;
   assign hdr.m_ip_dest_ip          = ip_q;
   assign hdr.m_roce_payload_length = pay_q;
`ifdef ROCE_WRITE_IMMDT_EN
   assign hdr.m_roce_immdt_data     = immdt_q;
`endif

   assign busy          = (state_q != StIdle);
   assign transfer_done = (state_q == StDone);
   assign next_psn      = next_psn_q;

endmodule

// File: doc/roce_write_sequencer.md
ROCE_WRITE_SEQUENCER -- requirements
Module: roce_write_sequencer

Interface
REQ-001 SHALL have parameter PMTU_BYTES, default 1024, path MTU in bytes; legal values 256/512/1024/2048/4096.
REQ-002 SHALL have ports clk, input, 1, sole clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have inputs start_transfer 1, metadata_valid 1, dma_transfer 32 (total bytes), r_key 32, rem_qpn 24, loc_psn 24, rem_ip_addr 32, rem_addr 64.
REQ-005 SHALL have outputs m_roce_bth_valid 1, m_roce_bth_op_code 8, m_roce_bth_psn 24, m_roce_bth_dest_qp 24, m_roce_reth_v_addr 64, m_roce_reth_r_key 32, m_roce_reth_length 32, m_ip_dest_ip 32, m_roce_payload_length 16 (bytes in this packet).
REQ-006 SHALL have input m_roce_bth_ready 1, and outputs busy 1, transfer_done 1 (one-cycle pulse), next_psn 24.

Function
REQ-007 SHALL detect a launch on the rising edge of (start_transfer AND metadata_valid), sampled only in state IDLE; a held-high level SHALL launch once.
REQ-008 SHALL, on launch, capture all metadata inputs in the same cycle; later input changes SHALL NOT affect the running transfer.
REQ-009 SHALL implement states IDLE -> ISSUE -> (ISSUE per packet) -> DONE -> IDLE.
REQ-010 SHALL assert m_roce_bth_valid the cycle after launch (latency 1).
REQ-011 SHALL issue N = ceil(dma_transfer / PMTU_BYTES) headers; every packet except the last carries PMTU_BYTES, last carries dma_transfer - (N-1)*PMTU_BYTES.
REQ-012 SHALL use opcode 0x0A (ONLY) when N=1; otherwise 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST.
REQ-013 SHALL set m_roce_reth_v_addr = captured rem_addr + k*PMTU_BYTES for packet k (0-based, 64-bit wrap), m_roce_reth_length = captured dma_transfer on all packets.
REQ-014 SHALL set packet k PSN = (loc_psn + k) mod 2^24.
REQ-015 SHALL hold all m_* fields stable while valid=1 and ready=0; a header is consumed only on valid AND ready; the next header SHALL be presented the following cycle (one header per cycle at full throughput).
REQ-016 SHALL, after the last header handshake, enter DONE for one cycle, pulse transfer_done, update next_psn = (loc_psn + N) mod 2^24, then return to IDLE.
REQ-017 SHALL treat dma_transfer = 0 as a launch with N=0: no header, transfer_done pulses two cycles after launch, next_psn = loc_psn.
REQ-018 SHALL ignore launch conditions while not in IDLE (no queueing).
REQ-019 SHALL drive busy = 1 in every state except IDLE.

Reset
REQ-020 SHALL, on rst assertion, immediately return to IDLE and drive m_roce_bth_valid=0, busy=0, transfer_done=0, next_psn=0, all other m_* outputs 0, without waiting for a clock edge.
REQ-021 SHALL abandon any in-progress transfer on reset; no partial header handshake completes after reset.
REQ-022 SHALL clear the start edge detector on reset so start_transfer high at deassertion launches once.

Configuration
REQ-023 SHALL support macro ROCE_WRITE_IMMDT_EN: when defined, adds input immdt_data 32 (captured at launch) and output m_roce_immdt_data 32, and final opcode becomes 0x09 (LAST w/ IMMDT) or 0x0B (ONLY w/ IMMDT); when undefined, these ports are absent and REQ-012 opcodes apply.

Verification
REQ-024 SHALL pass: PMTU 1024, len 1024, loc_psn 0x10, ready=1 -> one header op 0x0A, psn 0x10, payload 1024; transfer_done; next_psn 0x11.
REQ-025 SHALL pass: len 2500, rem_addr 0x1000 -> ops 06/07/08, payloads 1024/1024/452, v_addr 0x1000/0x1400/0x1800, PSN P/P+1/P+2 on consecutive cycles.
REQ-026 SHALL pass: loc_psn 0xFFFFFF, len 2048 -> FIRST psn 0xFFFFFF, LAST psn 0x000000, next_psn 0x000001.
REQ-027 SHALL pass: ready low 5 cycles on MIDDLE header -> all fields stable, no header lost or duplicated; start held high 100 cycles -> exactly one transfer.
REQ-028 SHALL pass: rst pulse during second of 4 packets -> valid=0 and busy=0 immediately, no further headers; with ROCE_WRITE_IMMDT_EN and len 512 -> single op 0x0B, m_roce_immdt_data equals captured immdt_data.
